// File: rtl/alu_chk_pkg.sv
// Shared types and constants for the ALU result checker.
package alu_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/alu_expect_pipe.sv
// Predicts the ALU result from the snooped operands and delays it so that
// the head of the line lines up with the ALU's registered data_out.
module alu_expect_pipe
  import alu_chk_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             op_sel_i,
  output logic             head_vld_o,
  output logic [WIDTH-1:0] head_exp_o
);

  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]   exp_q [LATENCY];
  logic [WIDTH-1:0]   exp_s;

  // Carry and borrow fall off the top: the ALU result is modulo 2^WIDTH.
  always_comb begin
    exp_s = '0;
    if (op_sel_i == OP_ADD) begin
      exp_s = op_a_i + op_b_i;
    end else begin
      exp_s = op_a_i - op_b_i;
    end
  end

  // Flush beats a same-cycle push so an aborted run leaves nothing behind.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        exp_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= push_i;
      exp_q[0] <= exp_s;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
    end
  end

  assign head_vld_o = vld_q[LATENCY-1];
  assign head_exp_o = exp_q[LATENCY-1];

endmodule

// File: rtl/alu_result_checker.sv
// Run controller for the ALU checker: accepts a run of num_checks results,
// compares each against the delayed prediction and records pass/fail counts.
module alu_result_checker
  import alu_chk_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int LATENCY      = 1,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_checks_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] operand1_i,
  input  logic [WIDTH-1:0] operand2_i,
  input  logic             op_sel_i,
  input  logic [WIDTH-1:0] data_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [CNT_W-1:0] pass_count_o,
  output logic [CNT_W-1:0] fail_count_o,
  output logic [WIDTH-1:0] fail_expected_o,
  output logic [WIDTH-1:0] fail_actual_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_e           state_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] checked_q;
  logic [CNT_W-1:0] checked_d;
  logic [CNT_W-1:0] pass_q;
  logic [CNT_W-1:0] fail_q;
  logic             error_q;
  logic [WIDTH-1:0] fail_exp_q;
  logic [WIDTH-1:0] fail_act_q;

  logic             in_run_s;
  logic             start_ok_s;
  logic             push_s;
  logic             cmp_s;
  logic             mismatch_s;
  logic             stop_s;
  logic             flush_s;
  logic             head_vld_s;
  logic [WIDTH-1:0] head_exp_s;

  alu_expect_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_s),
    .push_i     (push_s),
    .op_a_i     (operand1_i),
    .op_b_i     (operand2_i),
    .op_sel_i   (op_sel_i),
    .head_vld_o (head_vld_s),
    .head_exp_o (head_exp_s)
  );

  // checked_d lets the FSM leave RUN on the very edge of the final compare.
  always_comb begin
    in_run_s   = (state_q == RUN);
    start_ok_s = start_i && !in_run_s;
    push_s     = in_run_s && in_valid_i && (issued_q < target_q);
    cmp_s      = in_run_s && head_vld_s;
    mismatch_s = cmp_s && (head_exp_s != data_out_i);
    stop_s     = STOP_ON_FAIL && mismatch_s;
    flush_s    = start_ok_s || stop_s;
    if (cmp_s) begin
      checked_d = checked_q + CNT_ONE;
    end else begin
      checked_d = checked_q;
    end
  end

  // Run FSM with its counters and first-mismatch capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      target_q   <= '0;
      issued_q   <= '0;
      checked_q  <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      error_q    <= 1'b0;
      fail_exp_q <= '0;
      fail_act_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q    <= RUN;
            target_q   <= num_checks_i;
            issued_q   <= '0;
            checked_q  <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            error_q    <= 1'b0;
            fail_exp_q <= '0;
            fail_act_q <= '0;
          end
        end
        RUN: begin
          if (push_s) begin
            issued_q <= issued_q + CNT_ONE;
          end
          if (cmp_s) begin
            checked_q <= checked_d;
            if (mismatch_s) begin
              fail_q  <= sat_inc(fail_q);
              error_q <= 1'b1;
              if (fail_q == '0) begin
                fail_exp_q <= head_exp_s;
                fail_act_q <= data_out_i;
              end
            end else begin
              pass_q <= sat_inc(pass_q);
            end
          end
          if (stop_s || (checked_d == target_q)) begin
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o          = (state_q == RUN);
  assign done_o          = (state_q == DONE);
  assign error_o         = error_q;
  assign pass_count_o    = pass_q;
  assign fail_count_o    = fail_q;
  assign fail_expected_o = fail_exp_q;
  assign fail_actual_o   = fail_act_q;

endmodule
